// File: rtl/fios_mm_seq.sv
// Word-serial FIOS Montgomery multiplier with its own sequencer: res = a*b*R^-1 mod p, R = 2^(W*S).
// Define FIOS_MM_FINAL_SUB_EN to add the limb-serial final subtraction (result fully reduced).
module fios_mm_seq #(
    parameter int unsigned W = 17,
    parameter int unsigned S = 8
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           start_i,
    input  logic [W*S-1:0] a_i,
    input  logic [W*S-1:0] b_i,
    input  logic [W*S-1:0] p_i,
    input  logic [W-1:0]   p_prime_0_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [W*S-1:0] res_o
);
    localparam int unsigned CW = $clog2(S + 1);
    localparam int unsigned AW = 2 * W + 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
`ifdef FIOS_MM_FINAL_SUB_EN
        StSub  = 2'd3,
`endif
        StDone = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W*S-1:0] a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d;
    logic [W-1:0]   pp_q, pp_d, m_q, m_d;
    logic [W+1:0]   c_q, c_d;
    logic [CW-1:0]  i_q, i_d, j_q, j_d;
    logic [W-1:0]   t_q [S+1];
    logic [W-1:0]   t_d [S+1];
`ifdef FIOS_MM_FINAL_SUB_EN
    logic [W*S-1:0] d_q, d_d;
    logic           bor_q, bor_d;
    logic [W:0]     diff;
    logic [W*S-1:0] t_flat;
`endif

    logic [W-1:0]   a_limb, p_limb, b_limb, u, m_cur, m_sel;
    logic [2*W-1:0] ab, mp;
    logic [W+1:0]   c_in;
    logic [AW-1:0]  acc;
    logic           load_res;

    // Shared inner-step datapath; at j=S the a/p limbs are zero so acc = t[S] + C.
    always_comb begin
        a_limb = '0;
        p_limb = '0;
        if (j_q < CW'(S)) begin
            a_limb = a_q[j_q*W +: W];
            p_limb = p_q[j_q*W +: W];
        end
        b_limb = b_q[i_q*W +: W];
        ab     = (2*W)'(a_limb) * (2*W)'(b_limb);
        u      = t_q[0] + ab[W-1:0];
        m_cur  = u * pp_q;
        m_sel  = (j_q == '0) ? m_cur : m_q;
        mp     = (2*W)'(m_sel) * (2*W)'(p_limb);
        c_in   = (j_q == '0) ? '0 : c_q;
        acc    = AW'(t_q[j_q]) + AW'(ab) + AW'(mp) + AW'(c_in);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        pp_d     = pp_q;
        m_d      = m_q;
        c_d      = c_q;
        i_d      = i_q;
        j_d      = j_q;
        t_d      = t_q;
        res_d    = res_q;
        load_res = 1'b0;
`ifdef FIOS_MM_FINAL_SUB_EN
        d_d      = d_q;
        bor_d    = bor_q;
        diff     = '0;
        for (int k = 0; k < S; k++) t_flat[k*W +: W] = t_q[k];
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    p_d     = p_i;
                    pp_d    = p_prime_0_i;
                    t_d     = '{default: '0};
                    c_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (j_q == '0) m_d = m_cur;
                c_d = acc[AW-1:W];
                if (j_q == CW'(S)) begin
                    t_d[S-1] = acc[W-1:0];
                    t_d[S]   = acc[2*W-1:W];
                    j_d      = '0;
                    if (i_q == CW'(S - 1)) begin
`ifdef FIOS_MM_FINAL_SUB_EN
                        bor_d   = 1'b0;
                        state_d = StSub;
`else
                        load_res = 1'b1;
                        state_d  = StDone;
`endif
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    if (j_q != '0) t_d[j_q - CW'(1)] = acc[W-1:0];
                    j_d = j_q + CW'(1);
                end
            end
`ifdef FIOS_MM_FINAL_SUB_EN
            StSub: begin
                diff = {1'b0, t_q[j_q]} - {1'b0, p_limb} - (W+1)'(bor_q);
                d_d[j_q*W +: W] = diff[W-1:0];
                bor_d = diff[W];
                if (j_q == CW'(S - 1)) begin
                    // t >= p exactly when the chain ends without borrow or t[S] is set
                    res_d   = (!diff[W] || t_q[S] != '0) ? d_d : t_flat;
                    state_d = StDone;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (load_res) begin
            for (int k = 0; k < S; k++) res_d[k*W +: W] = t_d[k];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            pp_q    <= '0;
            m_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            t_q     <= '{default: '0};
            res_q   <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
            d_q     <= '0;
            bor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            pp_q    <= pp_d;
            m_q     <= m_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            t_q     <= t_d;
            res_q   <= res_d;
`ifdef FIOS_MM_FINAL_SUB_EN
            d_q     <= d_d;
            bor_q   <= bor_d;
`endif
        end
    end

`ifdef FIOS_MM_FINAL_SUB_EN
    assign busy_o = (state_q == StMul) || (state_q == StSub);
`else
    assign busy_o = (state_q == StMul);
`endif
    assign done_o = (state_q == StDone);
    assign res_o  = res_q;

endmodule

// File: tb/tb_fios_mm_seq.sv
// Directed bench for fios_mm_seq: small W=4,S=2 vectors with hand-derived results and timing,
// plus a W=17,S=8 instance checked for Montgomery congruence and range.
module tb_fios_mm_seq;
`ifdef FIOS_MM_FINAL_SUB_EN
    localparam int SUBC = 1;
`else
    localparam int SUBC = 0;
`endif
    localparam int LAT  = 1 + 2 * 3 + 2 * SUBC;
    localparam int BLAT = 1 + 8 * 9 + 8 * SUBC;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start, busy, done;
    logic [7:0] a, b, p, res;
    logic [3:0] pp;

    logic         bstart, bbusy, bdone;
    logic [135:0] ba, bb, bp, bres;
    logic [16:0]  bpp;

    int n_total = 0;
    int n_pass  = 0;

    fios_mm_seq #(.W(4), .S(2)) u_small (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .a_i(a), .b_i(b), .p_i(p),
        .p_prime_0_i(pp), .busy_o(busy), .done_o(done), .res_o(res)
    );

    fios_mm_seq #(.W(17), .S(8)) u_big (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(bstart), .a_i(ba), .b_i(bb), .p_i(bp),
        .p_prime_0_i(bpp), .busy_o(bbusy), .done_o(bdone), .res_o(bres)
    );

    task automatic chk(input string tag, input logic [279:0] obs, input logic [279:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] pv,
                          input logic [3:0] ppv, input logic [7:0] ev, input bit glitch,
                          input string tag);
        int n;
        int nb;
        @(negedge clk);
        a = av; b = bv; p = pv; pp = ppv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~av; b = ~bv; p = ~pv; pp = ~ppv;
        n = 1;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            start = glitch && (n == 3);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, LAT);
        chk({tag, " busy cycles"}, nb, LAT - 1);
        chk({tag, " res"}, res, ev);
        chk({tag, " busy at done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, done, 0);
        @(posedge clk); #1;
        chk({tag, " idle after"}, busy, 0);
    endtask

    task automatic run_big(input int idx);
        logic [159:0] r;
        logic [279:0] pw, aw, bw, rw, lhs, rhs;
        int unsigned inv, p0;
        int n;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bp = r[135:0];
        bp[135] = 1'b0;
        bp[0] = 1'b1;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ba = r[135:0] % bp;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bb = r[135:0] % bp;
        p0 = 32'(bp[16:0]);
        inv = p0;
        repeat (5) inv = (inv * (2 - p0 * inv)) & 32'h1ffff;
        bpp = 17'((0 - inv) & 32'h1ffff);
        @(negedge clk);
        bstart = 1'b1;
        @(posedge clk); #1;
        bstart = 1'b0;
        n = 1;
        while (!bdone && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        pw  = 280'(bp);
        aw  = 280'(ba);
        bw  = 280'(bb);
        rw  = 280'(bres);
        lhs = (rw << 136) % pw;
        rhs = (aw * bw) % pw;
        chk($sformatf("big%0d latency", idx), n, BLAT);
        chk($sformatf("big%0d congruence", idx), lhs, rhs);
        if (SUBC == 1) chk($sformatf("big%0d below p", idx), 280'(rw < pw), 1);
        else chk($sformatf("big%0d below 2p", idx), 280'(rw < (pw << 1)), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int nd;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; p = '0; pp = '0;
        bstart = 1'b0; ba = '0; bb = '0; bp = '0; bpp = '0;
        #3;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset res", res, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd1, 8'd1, 8'd13, 4'd11, 8'd3, 1'b0, "a1b1");
        run_op(8'd12, 8'd12, 8'd13, 4'd11, 8'd3, 1'b0, "a12b12");
        run_op(8'd0, 8'd7, 8'd13, 4'd11, 8'd0, 1'b0, "a0b7");
        run_op(8'd5, 8'd7, 8'd13, 4'd11, 8'd1, 1'b1, "glitch");
        run_op(8'd100, 8'd99, 8'd101, 4'd3, (SUBC == 1) ? 8'd15 : 8'd116, 1'b0, "p101");

        // Abort in the third MUL cycle.
        @(negedge clk);
        a = 8'd5; b = 8'd7; p = 8'd13; pp = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-abort busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort res", res, 0);
        chk("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort no done", nd, 0);
        run_op(8'd1, 8'd1, 8'd13, 4'd11, 8'd3, 1'b0, "after abort");

        // start held high: next op accepted in the first IDLE cycle after done.
        @(negedge clk);
        a = 8'd12; b = 8'd12; p = 8'd13; pp = 4'd11; start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold first res", res, 3);
        @(posedge clk); #1;
        chk("hold idle gap", busy, 0);
        @(posedge clk); #1;
        chk("hold reaccept", busy, 1);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold second latency", n, LAT - 1);
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) run_big(i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
